// File: rtl/matrix_xpose_sched_pkg.sv
// Shared constants and types for the matrix transpose scheduler.
// Holds the operand geometry, FSM state encoding and requester-id type.
package matrix_xpose_sched_pkg;

    localparam int ELEM_W  = 8;
    localparam int DIM_MAX = 5;
    localparam int MAT_W   = DIM_MAX * DIM_MAX * ELEM_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef logic       req_id_t;
    typedef logic [2:0] dim_t;

    // A dimension pair is usable only when both sides are in 1..DIM_MAX.
    function automatic logic dims_ok(input dim_t m, input dim_t n);
        return (m != 3'd0) && (m <= 3'(DIM_MAX)) &&
               (n != 3'd0) && (n <= 3'(DIM_MAX));
    endfunction

endpackage

// File: rtl/matrix_xpose_sched_transpose.sv
// Combinational transpose unit: swaps rows and columns of an m x n operand
// inside a fixed 5x5 byte grid, zeroing everything outside the n x m result.
module matrix_xpose_sched_transpose
    import matrix_xpose_sched_pkg::ELEM_W, matrix_xpose_sched_pkg::DIM_MAX,
           matrix_xpose_sched_pkg::dim_t, matrix_xpose_sched_pkg::dims_ok;
#(
    parameter int MAT_W = matrix_xpose_sched_pkg::MAT_W
)(
    input  logic [2:0]       m_i,
    input  logic [2:0]       n_i,
    input  logic [MAT_W-1:0] mat_i,
    output logic [MAT_W-1:0] result_o,
    output logic [2:0]       m_out_o,
    output logic [2:0]       n_out_o,
    output logic             err_o
);

    logic valid;

    assign valid   = dims_ok(dim_t'(m_i), dim_t'(n_i));
    assign err_o   = ~valid;
    assign m_out_o = valid ? n_i : 3'd0;
    assign n_out_o = valid ? m_i : 3'd0;

    // Move element (i,j) to (j,i) for the live region; padding stays zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        result_o = '0;
        for (int i = 0; i < DIM_MAX; i++) begin
            for (int j = 0; j < DIM_MAX; j++) begin
                if (valid && (3'(i) < m_i) && (3'(j) < n_i)) begin
                    result_o[(j*DIM_MAX + i)*ELEM_W +: ELEM_W] =
                        mat_i[(i*DIM_MAX + j)*ELEM_W +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_xpose_sched.sv
// Two-requester transpose scheduler: round-robin arbitration in IDLE,
// one LAUNCH cycle through the transpose unit, then the result is held
// in HOLD until the consumer acks or the ack timeout expires.
module matrix_xpose_sched
    import matrix_xpose_sched_pkg::state_t, matrix_xpose_sched_pkg::ST_IDLE,
           matrix_xpose_sched_pkg::ST_LAUNCH, matrix_xpose_sched_pkg::ST_HOLD,
           matrix_xpose_sched_pkg::req_id_t;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int MAT_W       = matrix_xpose_sched_pkg::MAT_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       m0,
    input  logic [2:0]       n0,
    input  logic [2:0]       m1,
    input  logic [2:0]       n1,
    input  logic [MAT_W-1:0] mat0,
    input  logic [MAT_W-1:0] mat1,
    input  logic             ack,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err,
    output logic [2:0]       m_out,
    output logic [2:0]       n_out,
    output logic [MAT_W-1:0] result,
    output logic             timeout
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state_q;
    req_id_t          ptr_q;
    req_id_t          id_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       m_q;
    logic [2:0]       n_q;
    logic [MAT_W-1:0] mat_q;

    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic             err_q;
    logic [2:0]       m_out_q;
    logic [2:0]       n_out_q;
    logic [MAT_W-1:0] result_q;
    logic             timeout_q;

    req_id_t          gnt_id_d;
    logic [2:0]       m_d;
    logic [2:0]       n_d;
    logic [MAT_W-1:0] mat_d;

    logic [MAT_W-1:0] xp_result;
    logic [2:0]       xp_m_out;
    logic [2:0]       xp_n_out;
    logic             xp_err;

    // Pick the winner among pending requests and steer its operands.
    always_comb begin
        gnt_id_d = req_id_t'(req1);
        if (req0 && req1) begin
            gnt_id_d = ~ptr_q;
        end
        m_d   = gnt_id_d ? m1   : m0;
        n_d   = gnt_id_d ? n1   : n0;
        mat_d = gnt_id_d ? mat1 : mat0;
    end

    matrix_xpose_sched_transpose #(
        .MAT_W (MAT_W)
    ) u_transpose_unit (
        .m_i      (m_q),
        .n_i      (n_q),
        .mat_i    (mat_q),
        .result_o (xp_result),
        .m_out_o  (xp_m_out),
        .n_out_o  (xp_n_out),
        .err_o    (xp_err)
    );

    // Sequencer: arbitration, operand latch, result capture and ack/timeout.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values, independent of statement order.
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b1;
            id_q      <= 1'b0;
            cnt_q     <= '0;
            m_q       <= '0;
            n_q       <= '0;
            mat_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
            m_out_q   <= '0;
            n_out_q   <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= ST_LAUNCH;
                        busy_q  <= 1'b1;
                        id_q    <= gnt_id_d;
                        ptr_q   <= gnt_id_d;
                        m_q     <= m_d;
                        n_q     <= n_d;
                        mat_q   <= mat_d;
                        gnt0_q  <= ~gnt_id_d;
                        gnt1_q  <= gnt_id_d;
                    end
                end
                ST_LAUNCH: begin
                    state_q   <= ST_HOLD;
                    cnt_q     <= '0;
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    err_q     <= xp_err;
                    m_out_q   <= xp_m_out;
                    n_out_q   <= xp_n_out;
                    result_q  <= xp_result;
                end
                ST_HOLD: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;
    assign m_out   = m_out_q;
    assign n_out   = n_out_q;
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_matrix_xpose_sched.sv
// Scoreboard bench for matrix_xpose_sched: stimulus pushes hand-computed
// results into a queue, a monitor pops and compares on each new done.
module tb_matrix_xpose_sched;

    localparam int MW = 200;
    localparam int TO = 16;

    typedef struct {
        logic          id;
        logic          err;
        logic [2:0]    m_out;
        logic [2:0]    n_out;
        logic [MW-1:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
    logic [2:0]    m0 = '0, n0 = '0, m1 = '0, n1 = '0;
    logic [MW-1:0] mat0 = '0, mat1 = '0;
    logic          gnt0, gnt1, busy, done, done_id, err, timeout;
    logic [2:0]    m_out, n_out;
    logic [MW-1:0] result;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    matrix_xpose_sched #(.ACK_TIMEOUT(TO), .MAT_W(MW)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .m0(m0), .n0(n0), .m1(m1), .n1(n1), .mat0(mat0), .mat1(mat1),
        .ack(ack), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .err(err), .m_out(m_out), .n_out(n_out),
        .result(result), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] setb(input logic [MW-1:0] v, input int idx, input logic [7:0] b);
        v[idx*8 +: 8] = b;
        return v;
    endfunction

    function automatic exp_t mk(input logic id, input logic e, input logic [2:0] mo,
                                input logic [2:0] no, input logic [MW-1:0] r);
        exp_t x;
        x.id = id; x.err = e; x.m_out = mo; x.n_out = no; x.res = r;
        return x;
    endfunction

    // Monitor: compare each new result against the scoreboard; check hold stability.
    logic         done_prev = 1'b0;
    logic [207:0] snap = '0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_underflow: got done with empty scoreboard");
            end else begin
                e = sb.pop_front();
                check("done_id", done_id, e.id);
                check("err", err, e.err);
                check("m_out", m_out, e.m_out);
                check("n_out", n_out, e.n_out);
                check("result", result, e.res);
            end
        end else if (done && done_prev) begin
            check("hold_stable", {done_id, err, m_out, n_out, result}, snap);
        end
        done_prev = done;
        snap      = {done_id, err, m_out, n_out, result};
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_grant(output logic id, output bit ok);
        ok = 1'b0; id = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                id = gnt1;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL grant_wait: got no grant expected one within 10 cycles");
        end
    endtask

    task automatic run_op(input logic id, input logic [2:0] m, input logic [2:0] n,
                          input logic [MW-1:0] mat, input exp_t e);
        logic gid;
        bit   ok;
        if (id) begin m1 = m; n1 = n; mat1 = mat; req1 = 1'b1; end
        else    begin m0 = m; n0 = n; mat0 = mat; req0 = 1'b1; end
        sb.push_back(e);
        wait_grant(gid, ok);
        req0 = 1'b0; req1 = 1'b0;
        if (ok) check("gnt_id", gid, id);
        cyc(1);
        check("done_in_hold", done, 1'b1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("ack_clears", {done, busy}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected one before 100000");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] a, r, a1;
        logic          gid;
        bit            ok;
        logic          order [3];
        order = '{1'b0, 1'b1, 1'b0};

        // Reset state
        cyc(3);
        check("rst_ctrl", {gnt0, gnt1, busy, done, done_id, err, m_out, n_out, timeout}, '0);
        check("rst_result", result, '0);
        reset = 1'b1;
        cyc(1);

        // Single request, 2x3 with padding garbage, latency check
        a = {25{8'hEE}};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                a = setb(a, i*5 + j, 8'(i*3 + j + 1));
        r = '0;
        r = setb(r, 0, 8'd1);  r = setb(r, 1, 8'd4);
        r = setb(r, 5, 8'd2);  r = setb(r, 6, 8'd5);
        r = setb(r, 10, 8'd3); r = setb(r, 11, 8'd6);
        sb.push_back(mk(1'b0, 1'b0, 3'd3, 3'd2, r));
        m0 = 3'd2; n0 = 3'd3; mat0 = a; req0 = 1'b1;
        cyc(1);
        check("lat_gnt_t1", {gnt0, gnt1, done, busy}, 4'b1001);
        req0 = 1'b0;
        cyc(1);
        check("lat_done_t2", {gnt0, done, busy}, 3'b011);
        cyc(2);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("single_ack", {done, busy, timeout}, 3'b000);

        // Contention from reset: grants alternate 0,1,0
        reset = 1'b0;
        a  = {25{8'h55}}; a  = setb(a, 0, 8'hA1);  a  = setb(a, 1, 8'hA2);
        a1 = {25{8'h66}}; a1 = setb(a1, 0, 8'hB1); a1 = setb(a1, 5, 8'hB2);
        m0 = 3'd1; n0 = 3'd2; mat0 = a;
        m1 = 3'd2; n1 = 3'd1; mat1 = a1;
        r = '0; r = setb(r, 0, 8'hA1); r = setb(r, 5, 8'hA2);
        sb.push_back(mk(1'b0, 1'b0, 3'd2, 3'd1, r));
        r = '0; r = setb(r, 0, 8'hB1); r = setb(r, 1, 8'hB2);
        sb.push_back(mk(1'b1, 1'b0, 3'd1, 3'd2, r));
        r = '0; r = setb(r, 0, 8'hA1); r = setb(r, 5, 8'hA2);
        sb.push_back(mk(1'b0, 1'b0, 3'd2, 3'd1, r));
        req0 = 1'b1; req1 = 1'b1;
        cyc(2);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(gid, ok);
            if (ok) check("rr_order", gid, order[k]);
            if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
            cyc(1);
            ack = 1'b1;
            cyc(1);
            ack = 1'b0;
        end

        // Invalid dims on requester 1
        run_op(1'b1, 3'd0, 3'd4, {25{8'h77}}, mk(1'b1, 1'b1, 3'd0, 3'd0, '0));
        run_op(1'b1, 3'd6, 3'd2, {25{8'h77}}, mk(1'b1, 1'b1, 3'd0, 3'd0, '0));

        // Ack held from IDLE through LAUNCH is ignored until HOLD
        ack = 1'b1;
        cyc(1);
        check("ack_idle_ignored", {busy, done}, 2'b00);
        a = '0; a = setb(a, 0, 8'h3C);
        sb.push_back(mk(1'b1, 1'b0, 3'd1, 3'd1, a));
        m1 = 3'd1; n1 = 3'd1; mat1 = a; req1 = 1'b1;
        wait_grant(gid, ok);
        req1 = 1'b0;
        cyc(1);
        check("ack_launch_ignored", done, 1'b1);
        cyc(1);
        check("ack_hold_exit", {done, busy}, 2'b00);
        ack = 1'b0;

        // Timeout after 16 HOLD cycles without ack
        a = '0; a = setb(a, 0, 8'h42);
        sb.push_back(mk(1'b0, 1'b0, 3'd1, 3'd1, a));
        m0 = 3'd1; n0 = 3'd1; mat0 = a; req0 = 1'b1;
        wait_grant(gid, ok);
        req0 = 1'b0;
        cyc(TO);
        check("to_hold16", {done, timeout}, 2'b10);
        cyc(1);
        check("to_pulse", {timeout, done, busy}, 3'b100);
        cyc(1);
        check("to_one_cycle", timeout, 1'b0);

        // Ack in the 16th HOLD cycle wins over the timeout
        sb.push_back(mk(1'b0, 1'b0, 3'd1, 3'd1, a));
        req0 = 1'b1;
        wait_grant(gid, ok);
        req0 = 1'b0;
        cyc(TO);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("ack_beats_to", {timeout, done, busy}, 3'b000);
        cyc(1);
        check("ack_beats_to_2", timeout, 1'b0);

        // Reset while holding a result from requester 0
        a = '0; a = setb(a, 0, 8'h99);
        sb.push_back(mk(1'b0, 1'b0, 3'd1, 3'd1, a));
        m0 = 3'd1; n0 = 3'd1; mat0 = a; req0 = 1'b1;
        wait_grant(gid, ok);
        req0 = 1'b0;
        cyc(1);
        check("pre_rst_done", done, 1'b1);
        reset = 1'b0;
        cyc(1);
        check("midrst_ctrl", {gnt0, gnt1, busy, done, done_id, err, m_out, n_out, timeout}, '0);
        check("midrst_result", result, '0);
        reset = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 3'd1, 3'd1, a));
        m1 = 3'd1; n1 = 3'd1; mat1 = '0;
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(gid, ok);
        req0 = 1'b0; req1 = 1'b0;
        if (ok) check("post_rst_gnt", gid, 1'b0);
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;

        // Boundary dims: 5x5 identity, 1x5 and 5x1 vectors with dirty padding
        a = '0;
        for (int i = 0; i < 5; i++) a = setb(a, i*6, 8'd1);
        r = '0;
        r = setb(r, 0, 8'd1); r = setb(r, 6, 8'd1); r = setb(r, 12, 8'd1);
        r = setb(r, 18, 8'd1); r = setb(r, 24, 8'd1);
        run_op(1'b0, 3'd5, 3'd5, a, mk(1'b0, 1'b0, 3'd5, 3'd5, r));

        a = {25{8'hFF}};
        for (int j = 0; j < 5; j++) a = setb(a, j, 8'(8'h10 + j));
        r = '0;
        r = setb(r, 0, 8'h10); r = setb(r, 5, 8'h11); r = setb(r, 10, 8'h12);
        r = setb(r, 15, 8'h13); r = setb(r, 20, 8'h14);
        run_op(1'b1, 3'd1, 3'd5, a, mk(1'b1, 1'b0, 3'd5, 3'd1, r));

        a = {25{8'hCC}};
        for (int i = 0; i < 5; i++) a = setb(a, i*5, 8'(8'h20 + i));
        r = '0;
        r = setb(r, 0, 8'h20); r = setb(r, 1, 8'h21); r = setb(r, 2, 8'h22);
        r = setb(r, 3, 8'h23); r = setb(r, 4, 8'h24);
        run_op(1'b0, 3'd5, 3'd1, a, mk(1'b0, 1'b0, 3'd1, 3'd5, r));

        cyc(3);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
